xmem_rdstream: RTL and testbench

Read-stream stage directly downstream of the two-level address generator in a Versat memory unit. Takes the generator's per-cycle address/enable/done and drives one synchronous RAM read port. Realigns read data with a delayed valid flag, counts returned words and raises a drained-done flag only once the RAM pipeline is empty. Its output stream feeds the unit's data-out register toward the Versat datapath.

---
 rtl/xmem_rdstream_pkg.sv | 24 ++
 rtl/xvalid_pipe.sv | 45 ++++
 rtl/xmem_rdstream.sv | 128 ++++++++++++
 tb/tb_xmem_rdstream.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/xmem_rdstream_pkg.sv
// -----------------------------------------------------------------------------
// xmem_rdstream_pkg
// Shared definitions for the Versat memory-unit read-stream stage:
//   - 2-bit state encoding of the read-stream controller
//   - legal range of the RAM read latency and a helper to check it
// -----------------------------------------------------------------------------
package xmem_rdstream_pkg;

  // Read-stream controller states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Supported RAM read latency range (cycles)
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;

  // True when a RAM latency value is one this stage can realign
  function automatic bit mem_lat_ok(input int lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/xvalid_pipe.sv
// -----------------------------------------------------------------------------
// xvalid_pipe
// DEPTH-deep valid-flag shift register with synchronous clear. Bit 0 takes
// in_i each cycle; the flag emerges on the last bit DEPTH cycles later.
// Ports:
//   clk_i   clock
//   rst_i   synchronous active-high reset
//   clr_i   synchronous clear (drops every flag in flight)
//   in_i    flag entering the pipe
//   last_o  flag on the last stage
//   empty_o no flag anywhere in the pipe
// -----------------------------------------------------------------------------
module xvalid_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic in_i,
  output logic last_o,
  output logic empty_o
);

  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH-1:0] pipe_d;

  // Next pipe contents: shift up one stage, new flag into bit 0
  always_comb begin
    pipe_d    = pipe_q << 1;
    pipe_d[0] = in_i;
  end

  // Pipe register; clear has priority over the incoming flag
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign last_o  = pipe_q[DEPTH-1];
  assign empty_o = (pipe_q == '0);

endmodule

// File: rtl/xmem_rdstream.sv
// -----------------------------------------------------------------------------
// xmem_rdstream
// Read-stream stage behind the two-level address generator. Drives one
// synchronous RAM read port from the generator, realigns returned data with a
// delayed valid flag, counts delivered words and reports done only once the
// RAM pipeline has drained.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   run_i                     start pulse (also restarts a busy stream)
//   ag_addr_i/ag_en_i/ag_done_i  address generator outputs
//   mem_addr_o/mem_en_o       RAM read port
//   mem_data_i                RAM data, valid MEM_LAT cycles after enable
//   data_o/valid_o            registered read word and its valid flag
//   count_o                   words delivered since last run_i (saturating)
//   busy_o/done_o             not idle / generator done and pipe drained
// -----------------------------------------------------------------------------
module xmem_rdstream
  import xmem_rdstream_pkg::*;
#(
  parameter int MEM_ADDR_W = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  run_i,
  input  logic [MEM_ADDR_W-1:0] ag_addr_i,
  input  logic                  ag_en_i,
  input  logic                  ag_done_i,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic                  mem_en_o,
  input  logic [DATA_W-1:0]     mem_data_i,
  output logic [DATA_W-1:0]     data_o,
  output logic                  valid_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  busy_o,
  output logic                  done_o
);

  if (!mem_lat_ok(MEM_LAT)) begin : g_bad_lat
    $error("xmem_rdstream: MEM_LAT out of range");
  end

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pipe_last_s;
  logic              pipe_empty_s;

  // Address always passes through; only the enable is gated by the state
  assign mem_addr_o = ag_addr_i;
  assign mem_en_o   = ag_en_i && ((state_q == ST_ARM) || (state_q == ST_RUN));

  // run_i flushes in-flight reads so a restarted stream never sees stale words
  xvalid_pipe #(
    .DEPTH (MEM_LAT)
  ) u_vpipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (run_i),
    .in_i    (mem_en_o),
    .last_o  (pipe_last_s),
    .empty_o (pipe_empty_s)
  );

  // Controller next state; run_i overrides everything, including ag_done_i
  always_comb begin
    state_d = state_q;
    if (run_i) begin
      state_d = ST_ARM;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        // ARM lasts one cycle so the generator's stale done is ignored
        ST_ARM:   state_d = ST_RUN;
        ST_RUN:   state_d = ag_done_i ? ST_DRAIN : ST_RUN;
        // Empty pipe means the word in the output register (if any) is the
        // last one, so done rises exactly the cycle after it
        ST_DRAIN: state_d = pipe_empty_s ? ST_IDLE : ST_DRAIN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Output word, valid flag and saturating delivered-word counter
  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    count_d = count_q;
    if (run_i) begin
      count_d = '0;
    end else if (pipe_last_s) begin
      data_d  = mem_data_i;
      valid_d = 1'b1;
      if (count_q != {CNT_W{1'b1}}) begin
        count_d = count_q + CNT_W'(1);
      end else begin
        count_d = count_q;
      end
    end else begin
      data_d = data_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign count_o = count_q;
  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = (state_q == ST_IDLE);

endmodule

// File: tb/tb_xmem_rdstream.sv
// -----------------------------------------------------------------------------
// tb_xmem_rdstream
// Three DUT lanes (MEM_LAT = 1, 2, 3, CNT_W = 4) share one generator stimulus.
// Each lane has its own latency-accurate RAM model. The reference keeps, per
// lane, a calendar of delivery cycles: a read accepted at cycle c is due on
// valid_o at cycle c+MEM_LAT+1 unless a run_i or rst_i intervenes.
// -----------------------------------------------------------------------------
module tb_xmem_rdstream;

  localparam int NL = 3;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CAL = 16;

  localparam int P_IDLE  = 0;
  localparam int P_ARM   = 1;
  localparam int P_RUN   = 2;
  localparam int P_DRAIN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i, run_i, ag_en_i, ag_done_i;
  logic [AW-1:0] ag_addr_i;

  logic [AW-1:0] mem_addr [NL];
  logic          mem_en   [NL];
  logic [DW-1:0] mem_data [NL];
  logic [DW-1:0] data_o   [NL];
  logic          valid_o  [NL];
  logic [CW-1:0] count_o  [NL];
  logic          busy_o   [NL];
  logic          done_o   [NL];

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return 32'(a) + 32'd100;
  endfunction

  for (genvar g = 0; g < NL; g++) begin : g_lane
    localparam int L = g + 1;
    logic [DW-1:0] rd_q [L];

    xmem_rdstream #(
      .MEM_ADDR_W (AW),
      .DATA_W     (DW),
      .MEM_LAT    (L),
      .CNT_W      (CW)
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .run_i      (run_i),
      .ag_addr_i  (ag_addr_i),
      .ag_en_i    (ag_en_i),
      .ag_done_i  (ag_done_i),
      .mem_addr_o (mem_addr[g]),
      .mem_en_o   (mem_en[g]),
      .mem_data_i (mem_data[g]),
      .data_o     (data_o[g]),
      .valid_o    (valid_o[g]),
      .count_o    (count_o[g]),
      .busy_o     (busy_o[g]),
      .done_o     (done_o[g])
    );

    // RAM with L-cycle read latency; garbage when not enabled
    always @(posedge clk) begin
      rd_q[0] <= mem_en[g] ? ram_word(mem_addr[g]) : 32'hDEAD_BEEF;
      for (int i = 1; i < L; i++) rd_q[i] <= rd_q[i-1];
    end
    assign mem_data[g] = rd_q[L-1];
  end

  // Reference model state
  int            ph      [NL];
  int            cnt     [NL];
  logic [DW-1:0] last_d  [NL];
  bit            sched_v [NL][CAL];
  logic [DW-1:0] sched_d [NL][CAL];
  int            cyc;
  int            n_checks;
  int            n_errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit any_pending(input int l);
    for (int s = 0; s < CAL; s++) if (sched_v[l][s]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic flush_lane(input int l);
    for (int s = 0; s < CAL; s++) sched_v[l][s] = 1'b0;
  endtask

  // One clock cycle: drive inputs, check every lane, advance the model
  task automatic step(input bit r, input bit rn, input bit en,
                      input logic [AW-1:0] a, input bit dn, input bit do_chk);
    @(negedge clk);
    rst_i = r; run_i = rn; ag_en_i = en; ag_addr_i = a; ag_done_i = dn;
    #1;
    for (int l = 0; l < NL; l++) begin
      int slot;
      bit ev;
      bit exp_en;
      slot = cyc % CAL;
      ev   = sched_v[l][slot];
      if (ev) begin
        sched_v[l][slot] = 1'b0;
        last_d[l] = sched_d[l][slot];
        if (cnt[l] != (1 << CW) - 1) cnt[l]++;
      end
      exp_en = en && (ph[l] == P_ARM || ph[l] == P_RUN);
      if (do_chk) begin
        check($sformatf("valid_L%0d", l + 1), 32'(valid_o[l]), 32'(ev));
        check($sformatf("data_L%0d", l + 1), data_o[l], last_d[l]);
        check($sformatf("count_L%0d", l + 1), 32'(count_o[l]), 32'(cnt[l]));
        check($sformatf("busy_L%0d", l + 1), 32'(busy_o[l]), 32'(ph[l] != P_IDLE));
        check($sformatf("done_L%0d", l + 1), 32'(done_o[l]), 32'(ph[l] == P_IDLE));
        check($sformatf("memen_L%0d", l + 1), 32'(mem_en[l]), 32'(exp_en));
        check($sformatf("addr_L%0d", l + 1), 32'(mem_addr[l]), 32'(a));
      end
      if (r) begin
        flush_lane(l);
        ph[l] = P_IDLE; cnt[l] = 0; last_d[l] = '0;
      end else if (rn) begin
        flush_lane(l);
        ph[l] = P_ARM; cnt[l] = 0;
      end else begin
        if (exp_en) begin
          sched_v[l][(cyc + l + 2) % CAL] = 1'b1;
          sched_d[l][(cyc + l + 2) % CAL] = ram_word(a);
        end
        case (ph[l])
          P_ARM:   ph[l] = P_RUN;
          P_RUN:   if (dn) ph[l] = P_DRAIN;
          P_DRAIN: if (!any_pending(l)) ph[l] = P_IDLE;
          default: ph[l] = ph[l];
        endcase
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
  endtask

  initial begin
    int pat [6];
    n_checks = 0; n_errors = 0; cyc = 0;
    for (int l = 0; l < NL; l++) begin
      ph[l] = P_IDLE; cnt[l] = 0; last_d[l] = '0;
      flush_lane(l);
    end
    rst_i = 1'b1; run_i = 1'b0; ag_en_i = 1'b0; ag_addr_i = '0; ag_done_i = 1'b0;

    // Reset held two cycles; state is unknown during the first
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    idle(2);

    // Basic stream: addresses 0..7 back to back from the ARM cycle
    step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, AW'(i), 1'b0, 1'b1);
    idle(8);

    // Gapped enables 1,0,1,1,0,1
    pat = '{1, 0, 1, 1, 0, 1};
    step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, pat[i][0], AW'(20 + i), 1'b0, 1'b1);
    idle(8);

    // Stale done held through run_i and ARM, then dropped
    step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 10'd40, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, AW'(41 + i), 1'b0, 1'b1);
    idle(8);

    // Restart with reads in flight
    step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 10'd60, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 10'd61, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, AW'(70 + i), 1'b0, 1'b1);
    idle(8);

    // Long stream: counter saturates at all ones
    step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, AW'(200 + i), 1'b0, 1'b1);
    idle(8);

    // Reset in DRAIN with reads outstanding
    step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, AW'(300 + i), 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 10'd303, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    idle(6);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 150) == 0, ($urandom % 25) == 0, ($urandom % 3) != 0,
           AW'($urandom % 1024), ($urandom % 6) == 0, 1'b1);
    end
    idle(8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
